// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the time-shared ripple-carry adder controller.
package adder_ctrl_pkg;

  localparam int ADDER_WIDTH       = 8;
  localparam int DEF_NREQ          = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder: bit 0 is the LSB, the carry runs from bit 0 upward.
module ripple_carry_adder
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o
);

  logic [WIDTH:0] c;

  assign c[0] = cin_i;

  for (genvar k = 0; k < WIDTH; k++) begin : g_fa
    assign s_o[k]   = a_i[k] ^ b_i[k] ^ c[k];
    assign c[k+1]   = (a_i[k] & b_i[k]) | (c[k] & (a_i[k] ^ b_i[k]));
  end

  assign cout_o = c[WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      j = (int'(ptr_i) + off) % NREQ;
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        idx_o      = IDW'(j);
        grant_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one ripple-carry adder among NREQ requesters: round-robin grant,
// operands held SETTLE_CYCLES on the adder, registered result with backpressure.
module adder_share_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter  int NREQ          = DEF_NREQ,
  parameter  int WIDTH         = ADDER_WIDTH,
  parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int IDW           = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready,
  output logic                  busy
);

  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (WIDTH != ADDER_WIDTH) begin : g_bad_width
    $error("adder_share_ctrl: WIDTH must equal the adder width");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("adder_share_ctrl: SETTLE_CYCLES must be at least 1");
  end

  state_t            state_q;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d, op_id_q, res_id_q, gnt_idx;
  logic [CNTW-1:0]   cnt_q;
  logic [WIDTH-1:0]  op_a_q, op_b_q, res_sum_q, add_s;
  logic              op_cin_q, res_cout_q, res_valid_q, add_cout;
  logic [NREQ-1:0]   gnt_oh;
  logic              gnt_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt_oh),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  // The adder only ever sees the held operand registers.
  ripple_carry_adder #(.WIDTH(WIDTH)) u_add (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .cin_i  (op_cin_q),
    .s_o    (add_s),
    .cout_o (add_cout)
  );

  // Ready is masked during reset so a requester never sees a phantom transfer.
  assign req_ready = (state_q == IDLE && !rst) ? gnt_oh : '0;
  assign rr_ptr_d  = (op_id_q == IDW'(NREQ - 1)) ? '0 : op_id_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      op_id_q     <= '0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            op_a_q   <= req_a[gnt_idx*WIDTH +: WIDTH];
            op_b_q   <= req_b[gnt_idx*WIDTH +: WIDTH];
            op_cin_q <= req_cin[gnt_idx];
            op_id_q  <= gnt_idx;
            cnt_q    <= CNTW'(SETTLE_CYCLES - 1);
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            res_sum_q   <= add_s;
            res_cout_q  <= add_cout;
            res_id_q    <= op_id_q;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // rr_ptr moves only when the result drains, never on grant.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with NREQ=4, SETTLE_CYCLES=2.
module tb_adder_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_cin;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [7:0]  res_sum;
  logic        res_cout;
  logic [1:0]  res_id;
  logic        res_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_share_ctrl #(.NREQ(4), .WIDTH(8), .SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [7:0] a, input logic [7:0] b, input logic cin);
    req_a[p*8 +: 8] = a;
    req_b[p*8 +: 8] = b;
    req_cin[p]      = cin;
    req_valid[p]    = 1'b1;
  endtask

  task automatic clr_req(input int p);
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_res(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (res_valid) begin
        timed_out = 1'b0;
        break;
      end
      tick();
    end
  endtask

  // Drives one request to completion with res_ready held high; returns the result.
  task automatic run_op(input int p, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] s, output logic co, output logic [1:0] id,
                        output bit timed_out);
    bit got;
    got = 1'b0;
    s = '0; co = 1'b0; id = '0;
    set_req(p, a, b, cin);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[p]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      clr_req(p);
      timed_out = 1'b1;
      return;
    end
    tick();
    clr_req(p);
    wait_res(timed_out);
    s  = res_sum;
    co = res_cout;
    id = res_id;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; res_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if ({res_cout, res_sum, res_id} !== 11'h000) begin errors++; $display("FAIL reset_result: got %h expected 000", {res_cout, res_sum, res_id}); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    set_req(0, 8'h3C, 8'hA5, 1'b1);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick();
    clr_req(0);
    checks++; if ({busy, res_valid} !== 2'b10) begin errors++; $display("FAIL single_c1: got busy/valid %b expected 10", {busy, res_valid}); end
    tick();
    checks++; if ({busy, res_valid} !== 2'b10) begin errors++; $display("FAIL single_c2: got busy/valid %b expected 10", {busy, res_valid}); end
    tick();
    checks++; if ({busy, res_valid} !== 2'b11) begin errors++; $display("FAIL single_c3: got busy/valid %b expected 11", {busy, res_valid}); end
    checks++; if ({res_cout, res_sum, res_id} !== {1'b0, 8'hE2, 2'd0}) begin errors++; $display("FAIL single_result: got %h expected %h", {res_cout, res_sum, res_id}, {1'b0, 8'hE2, 2'd0}); end
    tick();
    checks++; if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL single_drain: got busy/valid %b expected 00", {busy, res_valid}); end
  endtask

  task automatic test_carry();
    logic [7:0] s; logic co; logic [1:0] id; bit to;
    run_op(2, 8'hFF, 8'h01, 1'b0, s, co, id, to);
    checks++; if (to) begin errors++; $display("FAIL carry1_timeout: got timeout expected result"); end
    checks++; if ({co, s, id} !== {1'b1, 8'h00, 2'd2}) begin errors++; $display("FAIL carry1: got %h expected %h", {co, s, id}, {1'b1, 8'h00, 2'd2}); end
    run_op(2, 8'h7F, 8'h80, 1'b1, s, co, id, to);
    checks++; if (to) begin errors++; $display("FAIL carry2_timeout: got timeout expected result"); end
    checks++; if ({co, s, id} !== {1'b1, 8'h00, 2'd2}) begin errors++; $display("FAIL carry2: got %h expected %h", {co, s, id}, {1'b1, 8'h00, 2'd2}); end
  endtask

  task automatic test_contention();
    logic [7:0] s; logic co; logic [1:0] id; bit to;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 * (i + 1)), 8'(i), 1'b0);
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL cont_ready_in_reset: got %b expected 0000", req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL cont_first_grant: got %b expected 0001", req_ready); end
    for (int k = 0; k < 5; k++) begin
      wait_res(to);
      checks++; if (to) begin errors++; $display("FAIL cont_timeout_%0d: got timeout expected result", k); end
      checks++;
      if ({res_id, res_sum} !== {2'(k % 4), 8'(8'h10 * (k % 4 + 1) + k % 4)}) begin
        errors++;
        $display("FAIL cont_order_%0d: got id/sum %h expected %h", k, {res_id, res_sum}, {2'(k % 4), 8'(8'h10 * (k % 4 + 1) + k % 4)});
      end
      if (k == 4) req_valid = '0;
      tick();
    end
    run_op(1, 8'h01, 8'h01, 1'b0, s, co, id, to);
    checks++; if (to || {co, s, id} !== {1'b0, 8'h02, 2'd1}) begin errors++; $display("FAIL cont_port1: got %h expected %h", {co, s, id}, {1'b0, 8'h02, 2'd1}); end
    set_req(1, 8'hC8, 8'h64, 1'b1);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL cont_wrap_grant: got %b expected 0010", req_ready); end
    tick();
    clr_req(1);
    wait_res(to);
    checks++; if (to || {res_cout, res_sum, res_id} !== {1'b1, 8'h2D, 2'd1}) begin errors++; $display("FAIL cont_wrap_result: got %h expected %h", {res_cout, res_sum, res_id}, {1'b1, 8'h2D, 2'd1}); end
    tick();
  endtask

  task automatic test_backpressure();
    bit to;
    res_ready = 1'b0;
    set_req(0, 8'h55, 8'h2A, 1'b1);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0: got %b expected 0001", req_ready); end
    tick();
    clr_req(0);
    set_req(3, 8'h01, 8'h02, 1'b0);
    wait_res(to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout: got timeout expected result"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({res_valid, res_cout, res_sum, res_id, req_ready} !== {1'b1, 1'b0, 8'h80, 2'd0, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got %h expected %h", i, {res_valid, res_cout, res_sum, res_id, req_ready}, {1'b1, 1'b0, 8'h80, 2'd0, 4'b0000});
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if ({res_valid, req_ready} !== {1'b0, 4'b1000}) begin errors++; $display("FAIL bp_grant3: got %b expected 01000", {res_valid, req_ready}); end
    tick();
    clr_req(3);
    res_ready = 1'b1;
    wait_res(to);
    checks++; if (to || {res_cout, res_sum, res_id} !== {1'b0, 8'h03, 2'd3}) begin errors++; $display("FAIL bp_port3: got %h expected %h", {res_cout, res_sum, res_id}, {1'b0, 8'h03, 2'd3}); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] s; logic co; logic [1:0] id; bit to; bit seen;
    run_op(1, 8'h11, 8'h22, 1'b0, s, co, id, to);
    checks++; if (to || {co, s, id} !== {1'b0, 8'h33, 2'd1}) begin errors++; $display("FAIL rm_pre: got %h expected %h", {co, s, id}, {1'b0, 8'h33, 2'd1}); end
    set_req(2, 8'h10, 8'h20, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant2: got %b expected 0100", req_ready); end
    tick();
    clr_req(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL rm_after_rst: got busy/valid %b expected 00", {busy, res_valid}); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (res_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL rm_no_result: got res_valid 1 expected 0"); end
    set_req(1, 8'h99, 8'h66, 1'b0);
    set_req(3, 8'hAA, 8'hBB, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_ptr_zero: got %b expected 0010", req_ready); end
    tick();
    clr_req(1);
    clr_req(3);
    wait_res(to);
    checks++; if (to || {res_cout, res_sum, res_id} !== {1'b0, 8'hFF, 2'd1}) begin errors++; $display("FAIL rm_post: got %h expected %h", {res_cout, res_sum, res_id}, {1'b0, 8'hFF, 2'd1}); end
    tick();
  endtask

  task automatic test_withdrawn();
    bit to; bit bad;
    set_req(3, 8'h0F, 8'h01, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wd_grant3: got %b expected 1000", req_ready); end
    tick();
    clr_req(3);
    set_req(0, 8'hEE, 8'hEE, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_busy_ready: got %b expected 0000", req_ready); end
    tick();
    clr_req(0);
    wait_res(to);
    checks++; if (to || {res_cout, res_sum, res_id} !== {1'b0, 8'h10, 2'd3}) begin errors++; $display("FAIL wd_result: got %h expected %h", {res_cout, res_sum, res_id}, {1'b0, 8'h10, 2'd3}); end
    tick();
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ({busy, res_valid, req_ready} !== 6'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL wd_no_grant: got activity after withdrawal expected idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_withdrawn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
